datapath_seq: RTL
=================

DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus/register width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning general-purpose register count; legal values are powers of two from 2 to 64; SEL_W = clog2(NUM_REGS).
REQ-003 SHALL have port clock, input, 1 bit, meaning the single clock; every state element updates on its rising edge.
REQ-004 SHALL have port clear, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, meaning a request to execute one ALU instruction.
REQ-006 SHALL have port op, input, 4 bits, meaning the ALU operation code.
REQ-007 SHALL have ports ra/rb/rc, input, SEL_W bits each, meaning the destination, first source and second source registers.
REQ-008 SHALL have ports ld_en, input, 1 bit; ld_sel, input, SEL_W bits; and ld_data, input, DATA_W bits, together meaning an external register load.
REQ-009 SHALL have ports rd_sel, input, SEL_W bits, and rd_data, output, DATA_W bits, meaning a combinational read of R[rd_sel].
REQ-010 SHALL have ports hi and lo, output, DATA_W bits each, meaning the HI and LO registers.
REQ-011 SHALL have port busy, output, 1 bit, meaning an instruction is in flight.
REQ-012 SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit, meaning a one-cycle illegal-op pulse.

Function
REQ-014 SHALL use the following op encoding: 0 ADD, 1 SUB (Y-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SHRA, 8 ROL, 9 ROR, 10 NOT (of Y), 11 NEG (of Y), 12 MUL (signed, 2*DATA_W product); ops 13-15 are illegal.
REQ-015 SHALL use B[clog2(DATA_W)-1:0] as the shift/rotate amount and ignore the upper bits of B; ADD/SUB/NEG SHALL wrap modulo 2^DATA_W with no flags.
REQ-016 SHALL implement a state machine with states IDLE, LDY, LDZ, WBL, WBH and DONE.
REQ-017 SHALL accept start only in IDLE; on acceptance it latches op/ra/rb/rc and moves to LDY.
REQ-018 SHALL, in LDY, load Y <= R[rb] and move to LDZ.
REQ-019 SHALL, in LDZ, load Z (2*DATA_W bits) <= ALU(Y, R[rc]) and move to WBL.
REQ-020 SHALL, in WBL, write R[ra] <= Zlow for non-MUL ops and then move to DONE; for MUL it SHALL write LO <= Zlow and move to WBH.
REQ-021 SHALL, in WBH, write HI <= Zhigh and move to DONE.
REQ-022 SHALL, in DONE, assert done=1 for exactly that one cycle and then return to IDLE.
REQ-023 SHALL produce done 4 cycles after the accepting edge for non-MUL ops and 5 cycles after it for MUL.
REQ-024 SHALL drive busy=1 in every state except IDLE, including DONE; start while busy is ignored.
REQ-025 SHALL, when start is sampled in IDLE with an illegal op, keep the FSM in IDLE, modify no register, and assert err=1 for the next cycle only.
REQ-026 SHALL apply ld_en in IDLE only: R[ld_sel] <= ld_data; ld_en while busy=1 is ignored.
REQ-027 SHALL, when ld_en and start are both set in IDLE, commit the load on the same edge as the start acceptance, so a subsequent LDY/LDZ read sees the loaded value.
REQ-028 SHALL allow ra to equal rb and/or rc; the sources are read before writeback, so R[ra] receives the result computed from the old values.
REQ-029 SHALL make writes visible on rd_data in the cycle after the commit edge.

Reset
REQ-030 SHALL, on clear=1 at any edge including mid-operation, zero all R[i], Y, Z, HI, LO and the latched fields, go to IDLE, and force busy=0, done=0, err=0; clear overrides start and ld_en.
REQ-031 SHALL make all outputs 0 during the cycle after reset.

Verification
REQ-032 SHALL be verified by this ADD scenario: load R1=5 and R2=7, then start op=0 ra=3 rb=1 rc=2 -> done 4 cycles later, R3=12, busy high for 4 cycles.
REQ-033 SHALL be verified by this MUL scenario: R1=-3 and R2=4 at DATA_W=32, op=12 -> LO=0xFFFFFFF4, HI=0xFFFFFFFF, done 5 cycles after acceptance.
REQ-034 SHALL be verified by this illegal-op scenario: start op=14 -> err pulses for 1 cycle, busy stays 0, and all registers are unchanged.
REQ-035 SHALL be verified by this in-place rotate scenario: R4=0x80000001, op=8, ra=rb=4, rc=5 with R5=0x21 -> R4=0x00000003 (amount = 1).
REQ-036 SHALL be verified by this reset scenario: assert clear during LDZ of a SUB -> the next cycle busy=0, the destination register is 0, and no done pulse occurs.
REQ-037 SHALL be verified by this ignored-input scenario: ld_en and start asserted while busy -> both ignored and the in-flight result is unaffected; the bench SHALL also rerun with DATA_W=8 and NUM_REGS=4 and SHL by 9 -> shift by 1.

Source files
------------

// File: rtl/datapath_seq.sv
// ============================================================================
// datapath_seq : register-file datapath with multi-cycle sequenced ALU/MUL
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module datapath_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [SEL_W-1:0]  ra,
  input  logic [SEL_W-1:0]  rb,
  input  logic [SEL_W-1:0]  rc,
  input  logic              ld_en,
  input  logic [SEL_W-1:0]  ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDY  = 3'd1,
    LDZ  = 3'd2,
    WBL  = 3'd3,
    WBH  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic [3:0]          op_q;
  logic [SEL_W-1:0]    ra_q;
  logic [SEL_W-1:0]    rb_q;
  logic [SEL_W-1:0]    rc_q;

  logic                accept;
  logic                illegal_start;

  logic [DATA_W-1:0]   b_val;
  logic [SH_W-1:0]     amt;
  logic [2*DATA_W-1:0] rol_t;
  logic [2*DATA_W-1:0] ror_t;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   alu_lo;
  logic [2*DATA_W-1:0] alu_z;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    illegal_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op > OP_MUL) begin
            illegal_start = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = LDY;
          end
        end
      end
      LDY:     state_next = LDZ;
      LDZ:     state_next = WBL;
      WBL:     state_next = (op_q == OP_MUL) ? WBH : DONE;
      WBH:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      err   <= 1'b0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_next;
      err   <= illegal_start;
      if (accept) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      if (state == LDY) y <= regs[rb_q];
      if (state == LDZ) z <= alu_z;
      if (state == WBL && op_q == OP_MUL) lo <= z[DATA_W-1:0];
      if (state == WBH) hi <= z[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: external loads only in IDLE, results only in WBL, so the
  // two write ports can never collide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && ld_en) regs[ld_sel] <= ld_data;
      if (state == WBL && op_q != OP_MUL) regs[ra_q] <= z[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // ALU: rotates use a doubled operand so amount 0 needs no special case
  // ---------------------------------------------------------------------------
  always_comb begin
    b_val  = regs[rc_q];
    amt    = b_val[SH_W-1:0];
    rol_t  = {y, y} << amt;
    ror_t  = {y, y} >> amt;
    prod   = {{DATA_W{y[DATA_W-1]}}, y} * {{DATA_W{b_val[DATA_W-1]}}, b_val};
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = y + b_val;
      OP_SUB:  alu_lo = y - b_val;
      OP_AND:  alu_lo = y & b_val;
      OP_OR:   alu_lo = y | b_val;
      OP_XOR:  alu_lo = y ^ b_val;
      OP_SHL:  alu_lo = y << amt;
      OP_SHR:  alu_lo = y >> amt;
      OP_SHRA: alu_lo = $unsigned($signed(y) >>> amt);
      OP_ROL:  alu_lo = rol_t[2*DATA_W-1:DATA_W];
      OP_ROR:  alu_lo = ror_t[DATA_W-1:0];
      OP_NOT:  alu_lo = ~y;
      OP_NEG:  alu_lo = '0 - y;
      default: alu_lo = '0;
    endcase
    alu_z = (op_q == OP_MUL) ? prod : {{DATA_W{1'b0}}, alu_lo};
  end

  assign rd_data = regs[rd_sel];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

`default_nettype wire
